register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read, one-write register file with hardwired zero register
// Asynchronous active-low reset; optional read-during-write forwarding via BYPASS.
module register_file #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 0,
   localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            WE3,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic            wr_ok;
   logic            a1_ok;
   logic            a2_ok;

   // Address 0 and out-of-range addresses never hold data.
   assign wr_ok = rst_n && WE3 && (A3 != '0) && (int'(A3) < NREG);
   assign a1_ok = rst_n && (A1 != '0) && (int'(A1) < NREG);
   assign a2_ok = rst_n && (A2 != '0) && (int'(A2) < NREG);

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) begin
         regs_d[A3] = WD3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      RD1 = '0;
      RD2 = '0;
      if (a1_ok) begin
         RD1 = (BYPASS != 0 && wr_ok && A1 == A3) ? WD3 : regs_q[A1];
      end
      if (a2_ok) begin
         RD2 = (BYPASS != 0 && wr_ok && A2 == A3) ? WD3 : regs_q[A2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
// Drives a non-forwarding and a forwarding instance in parallel against an array model.
`timescale 1ns/1ps
module tb_register_file;

   logic        clk;
   logic        clk_en;
   logic        rst_n;
   logic        WE3;
   logic [4:0]  A1, A2, A3;
   logic [31:0] WD3;
   logic [31:0] rd1_nb, rd2_nb, rd1_b, rd2_b;

   int n_vec;
   int n_err;
   logic [31:0] mem [32];

   register_file #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .RD1(rd1_nb), .RD2(rd2_nb)
   );

   register_file #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
      .WD3(WD3), .RD1(rd1_b), .RD2(rd2_b)
   );

   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : clk;

   typedef struct {
      bit        we;
      bit [4:0]  a1, a2, a3;
      bit [31:0] wd;
      bit [31:0] e1_nb, e2_nb, e1_b, e2_b;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a, input bit fwd);
      if (!rst_n || a == 0) return 32'h0;
      if (fwd && WE3 && A3 != 0 && a == A3) return WD3;
      return mem[a];
   endfunction

   task automatic check_all(input string name);
      check({name, "/rd1_nb"}, rd1_nb, model_rd(A1, 1'b0));
      check({name, "/rd2_nb"}, rd2_nb, model_rd(A2, 1'b0));
      check({name, "/rd1_b"},  rd1_b,  model_rd(A1, 1'b1));
      check({name, "/rd2_b"},  rd2_b,  model_rd(A2, 1'b1));
   endtask

   // One clock edge with the model updated under the same rules; returns at the next negedge.
   task automatic step();
      @(posedge clk);
      if (rst_n && WE3 && A3 != 0) mem[A3] = WD3;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      clk_en = 1'b1;
      rst_n = 1'b0;
      WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
      clear_model();

      vecs[0] = '{1, 5, 5, 5, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{0, 5, 6, 6, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[2] = '{1, 6, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0};
      vecs[3] = '{1, 0, 5, 7, 32'h11111111, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[4] = '{1, 7, 0, 7, 32'h22222222, 32'h11111111, 32'h0,        32'h22222222, 32'h0};
      vecs[5] = '{0, 7, 7, 0, 32'h0,        32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
      vecs[6] = '{0, 0, 6, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};

      // Reset sweep, with a write attempted while held in reset.
      @(negedge clk);
      WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hA5A5A5A5;
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a);
         A2 = 5'(31 - a);
         #0.1;
         check("reset_rd1_nb", rd1_nb, 32'h0);
         check("reset_rd2_nb", rd2_nb, 32'h0);
         check("reset_rd1_b",  rd1_b,  32'h0);
         check("reset_rd2_b",  rd2_b,  32'h0);
      end
      @(negedge clk);
      WE3 = 1'b0;
      rst_n = 1'b1;
      A1 = 5'd3; #1;
      check("reset_blocks_write_nb", rd1_nb, 32'h0);
      check("reset_blocks_write_b",  rd1_b,  32'h0);

      // Directed table: pre-edge reads, then one edge.
      foreach (vecs[i]) begin
         WE3 = vecs[i].we; A1 = vecs[i].a1; A2 = vecs[i].a2; A3 = vecs[i].a3; WD3 = vecs[i].wd;
         #1;
         check($sformatf("vec%0d_rd1_nb", i), rd1_nb, vecs[i].e1_nb);
         check($sformatf("vec%0d_rd2_nb", i), rd2_nb, vecs[i].e2_nb);
         check($sformatf("vec%0d_rd1_b",  i), rd1_b,  vecs[i].e1_b);
         check($sformatf("vec%0d_rd2_b",  i), rd2_b,  vecs[i].e2_b);
         step();
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         WE3 = 1'($urandom_range(0, 3) != 0);
         A3  = 5'($urandom_range(0, 31));
         A1  = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
         A2  = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom_range(0, 31));
         WD3 = $urandom;
         #1;
         check("random", 32'h0, 32'h0 ^ (rd1_nb ^ model_rd(A1, 1'b0)));
         check("random_rd2_nb", rd2_nb, model_rd(A2, 1'b0));
         check("random_rd1_b",  rd1_b,  model_rd(A1, 1'b1));
         check("random_rd2_b",  rd2_b,  model_rd(A2, 1'b1));
         if (A1 == A2) check("same_addr_ports", rd1_b, rd2_b);
         step();
      end

      // Fill reg i with i, then reset asynchronously with the clock stopped.
      for (int i = 1; i < 32; i++) begin
         WE3 = 1'b1; A3 = 5'(i); WD3 = 32'(i);
         step();
      end
      WE3 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(i); #0.1;
         check("fill_rd1_nb", rd1_nb, 32'(i));
         check("fill_rd2_b",  rd2_b,  32'(i));
      end
      #1;
      clk_en = 1'b0;
      #2;
      rst_n = 1'b0;
      clear_model();
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(31 - i); #0.1;
         check("async_rst_rd1_nb", rd1_nb, 32'h0);
         check("async_rst_rd2_b",  rd2_b,  32'h0);
      end
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); #0.1;
         check("post_rst_cleared", rd1_nb, 32'h0);
      end
      clk_en = 1'b1;

      // First write after release lands on the first rising edge.
      @(negedge clk);
      WE3 = 1'b1; A3 = 5'd9; WD3 = 32'hCAFEF00D; A1 = 5'd9; A2 = 5'd9;
      #1;
      check_all("first_write_pre");
      step();
      WE3 = 1'b0; #1;
      check_all("first_write_post");
      check("first_write_val", rd1_nb, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
